// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and master FSM state codes.
// Also holds the alignment rule used to reject illegal single requests.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef logic [1:0] mst_state_t;

    localparam mst_state_t ST_IDLE = 2'd0;
    localparam mst_state_t ST_ADDR = 2'd1;
    localparam mst_state_t ST_DATA = 2'd2;
    localparam mst_state_t ST_RESP = 2'd3;

    // A request is illegal when its size is undefined or its address is not size-aligned.
    function automatic logic req_illegal(input logic [1:0] addr_lsb, input logic [2:0] size);
        logic bad;
        case (size)
            HSIZE_BYTE: bad = 1'b0;
            HSIZE_HALF: bad = addr_lsb[0];
            HSIZE_WORD: bad = addr_lsb[1] | addr_lsb[0];
            default:    bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ahb_lite_master_if_if.sv
// AHB-Lite bus bundle between one master and its slave/interconnect.
interface ahb_lite_master_if_if;

    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
        output HRDATA, HREADY, HRESP
    );

endinterface

// File: rtl/ahb_lite_master_if.sv
// Single-outstanding AHB-Lite master turning core requests into bus transfers.
// Optional INCR4 read line fill is enabled by defining AHB_MST_INCR4_EN.
module ahb_lite_master_if
    import ahb_pkg::*;
#(
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_size,
    input  logic        req_burst,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic        rsp_last,
    output logic [31:0] rsp_rdata,
    ahb_lite_master_if_if.master bus
);

    mst_state_t  state_r,     state_s;
    logic [1:0]  htrans_r,    htrans_s;
    logic [31:0] haddr_r,     haddr_s;
    logic        hwrite_r,    hwrite_s;
    logic [2:0]  hsize_r,     hsize_s;
    logic [31:0] hwdata_r,    hwdata_s;
    logic        rsp_valid_r, rsp_valid_s;
    logic        rsp_err_r,   rsp_err_s;
    logic        rsp_last_r,  rsp_last_s;
    logic [31:0] rsp_rdata_r, rsp_rdata_s;
    logic        req_ready_r, req_ready_s;
    logic        req_accept_s;
    logic        req_err_s;

`ifdef AHB_MST_INCR4_EN
    logic [2:0]  hburst_r, hburst_s;
    logic        burst_r,  burst_s;
    logic [1:0]  beat_r,   beat_s;

    // Line fills must be word reads on a 16-byte boundary; size input is ignored for them.
    assign req_err_s = req_burst ? (req_write | (req_addr[3:0] != 4'd0))
                                 : req_illegal(req_addr[1:0], req_size);
    assign bus.HBURST = hburst_r;
`else
    logic unused_req_burst_s;

    assign unused_req_burst_s = req_burst;
    assign req_err_s          = req_illegal(req_addr[1:0], req_size);
    assign bus.HBURST         = HBURST_SINGLE;
`endif

    assign req_accept_s = req_valid & req_ready_r;

    // Next-state and next-output computation for the transfer FSM.
    always_comb begin
        state_s     = state_r;
        htrans_s    = htrans_r;
        haddr_s     = haddr_r;
        hwrite_s    = hwrite_r;
        hsize_s     = hsize_r;
        hwdata_s    = hwdata_r;
        rsp_valid_s = 1'b0;
        rsp_err_s   = 1'b0;
        rsp_last_s  = 1'b0;
        rsp_rdata_s = rsp_rdata_r;
`ifdef AHB_MST_INCR4_EN
        hburst_s    = hburst_r;
        burst_s     = burst_r;
        beat_s      = beat_r;
`endif
        case (state_r)
            // RESP is the final cycle of a transfer and already takes the next request.
            ST_IDLE, ST_RESP: begin
                if (req_accept_s && req_err_s) begin
                    state_s     = ST_RESP;
                    rsp_valid_s = 1'b1;
                    rsp_err_s   = 1'b1;
                    rsp_last_s  = 1'b1;
                end else if (req_accept_s) begin
                    state_s  = ST_ADDR;
                    htrans_s = HTRANS_NONSEQ;
                    haddr_s  = req_addr;
                    hwrite_s = req_write;
                    hwdata_s = req_wdata;
`ifdef AHB_MST_INCR4_EN
                    burst_s  = req_burst;
                    beat_s   = 2'd0;
                    hburst_s = req_burst ? HBURST_INCR4 : HBURST_SINGLE;
                    hsize_s  = req_burst ? HSIZE_WORD : req_size;
`else
                    hsize_s  = req_size;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (bus.HREADY) begin
                    state_s = ST_DATA;
`ifdef AHB_MST_INCR4_EN
                    if (burst_r) begin
                        htrans_s = HTRANS_SEQ;
                        haddr_s  = haddr_r + 32'd4;
                    end else begin
                        htrans_s = HTRANS_IDLE;
                    end
`else
                    htrans_s = HTRANS_IDLE;
`endif
                end else begin
                    state_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (bus.HRESP) begin
                    // Two-cycle error: cancel any pending address, report on the second cycle.
                    htrans_s = HTRANS_IDLE;
                    if (bus.HREADY) begin
                        state_s     = ST_RESP;
                        rsp_valid_s = 1'b1;
                        rsp_err_s   = 1'b1;
                        rsp_last_s  = 1'b1;
                    end else begin
                        state_s = ST_DATA;
                    end
                end else if (bus.HREADY) begin
                    htrans_s    = HTRANS_IDLE;
                    rsp_valid_s = 1'b1;
                    if (!hwrite_r) begin
                        rsp_rdata_s = bus.HRDATA;
                    end else begin
                        rsp_rdata_s = rsp_rdata_r;
                    end
`ifdef AHB_MST_INCR4_EN
                    if (burst_r && (beat_r != 2'd3)) begin
                        state_s = ST_DATA;
                        beat_s  = beat_r + 2'd1;
                        // Beat 3's address already went out with beat 2's data phase.
                        if (beat_r != 2'd2) begin
                            htrans_s = HTRANS_SEQ;
                            haddr_s  = haddr_r + 32'd4;
                        end else begin
                            htrans_s = HTRANS_IDLE;
                        end
                    end else begin
                        state_s    = ST_RESP;
                        rsp_last_s = 1'b1;
                    end
`else
                    state_s    = ST_RESP;
                    rsp_last_s = 1'b1;
`endif
                end else begin
                    state_s = ST_DATA;
                end
            end
            default: begin
                state_s  = ST_IDLE;
                htrans_s = HTRANS_IDLE;
            end
        endcase
        req_ready_s = (state_s == ST_IDLE) || (state_s == ST_RESP);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_r     <= ST_IDLE;
            htrans_r    <= HTRANS_IDLE;
            haddr_r     <= 32'd0;
            hwrite_r    <= 1'b0;
            hsize_r     <= HSIZE_WORD;
            hwdata_r    <= 32'd0;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_last_r  <= 1'b0;
            rsp_rdata_r <= 32'd0;
            req_ready_r <= 1'b0;
`ifdef AHB_MST_INCR4_EN
            hburst_r    <= HBURST_SINGLE;
            burst_r     <= 1'b0;
            beat_r      <= 2'd0;
`endif
        end else begin
            state_r     <= state_s;
            htrans_r    <= htrans_s;
            haddr_r     <= haddr_s;
            hwrite_r    <= hwrite_s;
            hsize_r     <= hsize_s;
            hwdata_r    <= hwdata_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_err_r   <= rsp_err_s;
            rsp_last_r  <= rsp_last_s;
            rsp_rdata_r <= rsp_rdata_s;
            req_ready_r <= req_ready_s;
`ifdef AHB_MST_INCR4_EN
            hburst_r    <= hburst_s;
            burst_r     <= burst_s;
            beat_r      <= beat_s;
`endif
        end
    end

    assign bus.HADDR     = haddr_r;
    assign bus.HTRANS    = htrans_r;
    assign bus.HWRITE    = hwrite_r;
    assign bus.HSIZE     = hsize_r;
    assign bus.HPROT     = HPROT_VAL;
    assign bus.HMASTLOCK = 1'b0;
    assign bus.HWDATA    = hwdata_r;

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_err   = rsp_err_r;
    assign rsp_last  = rsp_last_r;
    assign rsp_rdata = rsp_rdata_r;

endmodule

// File: tb/tb_ahb_lite_master_if.sv
// Scoreboard bench for ahb_lite_master_if; burst scenarios build with AHB_MST_INCR4_EN.
module tb_ahb_lite_master_if;
    import ahb_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        req_valid, req_ready, req_write, req_burst;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_size;
    logic        rsp_valid, rsp_err, rsp_last;
    logic [31:0] rsp_rdata;

    ahb_lite_master_if_if bus();

    ahb_lite_master_if #(.HPROT_VAL(4'b0011)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata), .req_size(req_size),
        .req_burst(req_burst), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
        .rsp_last(rsp_last), .rsp_rdata(rsp_rdata), .bus(bus.master)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        last;
        logic        chk;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive_req(input logic [31:0] a, input logic w, input logic [31:0] d,
                             input logic [2:0] s, input logic b);
        req_valid = 1'b1;
        req_addr  = a;
        req_write = w;
        req_wdata = d;
        req_size  = s;
        req_burst = b;
    endtask

    task automatic test_reset();
        HRESETn = 1'b0; req_valid = 1'b0; req_addr = 32'd0; req_write = 1'b0;
        req_wdata = 32'd0; req_size = 3'd2; req_burst = 1'b0;
        bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = 32'd0;
        repeat (3) cyc();
        vectors++;
        if ({bus.HTRANS, bus.HADDR, bus.HWRITE, bus.HSIZE, bus.HBURST, bus.HWDATA} !==
            {2'b00, 32'd0, 1'b0, 3'b010, 3'b000, 32'd0}) begin
            miscompares++;
            $display("FAIL reset_bus: htrans=%b haddr=%h hwrite=%b hsize=%b hburst=%b hwdata=%h, want 00/0/0/010/000/0",
                     bus.HTRANS, bus.HADDR, bus.HWRITE, bus.HSIZE, bus.HBURST, bus.HWDATA);
        end
        vectors++;
        if ({rsp_valid, rsp_err, rsp_last, rsp_rdata, req_ready} !== {3'b000, 32'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_rsp: valid=%b err=%b last=%b rdata=%h ready=%b, want all 0",
                     rsp_valid, rsp_err, rsp_last, rsp_rdata, req_ready);
        end
        vectors++;
        if ({bus.HPROT, bus.HMASTLOCK} !== {4'b0011, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_prot: hprot=%b hmastlock=%b, want 0011/0", bus.HPROT, bus.HMASTLOCK);
        end
        HRESETn = 1'b1;
        cyc();
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready: req_ready=%b, want 1", req_ready);
        end
    endtask

    task automatic test_read();
        drive_req(32'h0010_0004, 1'b0, 32'd0, HSIZE_WORD, 1'b0);
        bus.HRDATA = 32'hDEAD_BEEF;
        sb.push_back('{32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1});
        cyc();
        req_valid = 1'b0;
        vectors++;
        if ({bus.HTRANS, bus.HADDR, bus.HWRITE, bus.HSIZE, req_ready} !==
            {HTRANS_NONSEQ, 32'h0010_0004, 1'b0, HSIZE_WORD, 1'b0}) begin
            miscompares++;
            $display("FAIL read_t1: htrans=%b haddr=%h hwrite=%b hsize=%b ready=%b, want 10/00100004/0/010/0",
                     bus.HTRANS, bus.HADDR, bus.HWRITE, bus.HSIZE, req_ready);
        end
        cyc();
        vectors++;
        if ({bus.HTRANS, rsp_valid} !== {HTRANS_IDLE, 1'b0}) begin
            miscompares++;
            $display("FAIL read_t2: htrans=%b rsp_valid=%b, want 00/0", bus.HTRANS, rsp_valid);
        end
        cyc();
        vectors++;
        if (rsp_valid !== 1'b1 || sb.size() == 0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL read_t3: rsp_valid=%b ready=%b queued=%0d, want 1/1/>0", rsp_valid, req_ready, sb.size());
        end else begin
            e = sb.pop_front();
            if (rsp_err !== e.err || rsp_last !== e.last || (e.chk && rsp_rdata !== e.rdata)) begin
                miscompares++;
                $display("FAIL read_rsp: err=%b last=%b rdata=%h, want %b/%b/%h", rsp_err, rsp_last, rsp_rdata, e.err, e.last, e.rdata);
            end
        end
        cyc();
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL read_t4_pulse: rsp_valid=%b, want 0", rsp_valid);
        end
    endtask

    task automatic test_write_wait();
        drive_req(32'h0010_0008, 1'b1, 32'hA5A5_0001, HSIZE_WORD, 1'b0);
        sb.push_back('{32'd0, 1'b0, 1'b1, 1'b0});
        cyc();
        req_valid = 1'b0;
        vectors++;
        if ({bus.HTRANS, bus.HADDR, bus.HWRITE} !== {HTRANS_NONSEQ, 32'h0010_0008, 1'b1}) begin
            miscompares++;
            $display("FAIL write_t1: htrans=%b haddr=%h hwrite=%b, want 10/00100008/1", bus.HTRANS, bus.HADDR, bus.HWRITE);
        end
        for (int c = 2; c <= 5; c++) begin
            cyc();
            bus.HREADY = (c == 5) ? 1'b1 : 1'b0;
            vectors++;
            if ({bus.HWDATA, bus.HTRANS, rsp_valid} !== {32'hA5A5_0001, HTRANS_IDLE, 1'b0}) begin
                miscompares++;
                $display("FAIL write_data_t%0d: hwdata=%h htrans=%b rsp_valid=%b, want a5a50001/00/0", c, bus.HWDATA, bus.HTRANS, rsp_valid);
            end
        end
        cyc();
        vectors++;
        if (rsp_valid !== 1'b1 || sb.size() == 0) begin
            miscompares++;
            $display("FAIL write_t6: rsp_valid=%b queued=%0d, want 1/>0", rsp_valid, sb.size());
        end else begin
            e = sb.pop_front();
            if (rsp_err !== e.err || rsp_last !== e.last) begin
                miscompares++;
                $display("FAIL write_rsp: err=%b last=%b, want %b/%b", rsp_err, rsp_last, e.err, e.last);
            end
        end
    endtask

    task automatic test_addr_wait();
        drive_req(32'h0010_0042, 1'b0, 32'd0, HSIZE_HALF, 1'b0);
        bus.HRDATA = 32'h1234_5678;
        sb.push_back('{32'h1234_5678, 1'b0, 1'b1, 1'b1});
        cyc();
        req_valid = 1'b0;
        bus.HREADY = 1'b0;
        cyc();
        bus.HREADY = 1'b1;
        vectors++;
        if ({bus.HTRANS, bus.HADDR, bus.HSIZE} !== {HTRANS_NONSEQ, 32'h0010_0042, HSIZE_HALF}) begin
            miscompares++;
            $display("FAIL addr_wait_hold: htrans=%b haddr=%h hsize=%b, want 10/00100042/001", bus.HTRANS, bus.HADDR, bus.HSIZE);
        end
        cyc();
        vectors++;
        if ({bus.HTRANS, rsp_valid} !== {HTRANS_IDLE, 1'b0}) begin
            miscompares++;
            $display("FAIL addr_wait_t3: htrans=%b rsp_valid=%b, want 00/0", bus.HTRANS, rsp_valid);
        end
        cyc();
        vectors++;
        if (rsp_valid !== 1'b1 || sb.size() == 0) begin
            miscompares++;
            $display("FAIL addr_wait_t4: rsp_valid=%b queued=%0d, want 1/>0", rsp_valid, sb.size());
        end else begin
            e = sb.pop_front();
            if (rsp_err !== e.err || rsp_last !== e.last || (e.chk && rsp_rdata !== e.rdata)) begin
                miscompares++;
                $display("FAIL addr_wait_rsp: err=%b last=%b rdata=%h, want %b/%b/%h", rsp_err, rsp_last, rsp_rdata, e.err, e.last, e.rdata);
            end
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] addrs [3] = '{32'h0010_0002, 32'h0010_0003, 32'h0010_0000};
        logic [2:0]  sizes [3] = '{3'd2, 3'd1, 3'd3};
        cyc();
        for (int i = 0; i < 3; i++) begin
            drive_req(addrs[i], 1'b0, 32'd0, sizes[i], 1'b0);
            sb.push_back('{32'd0, 1'b1, 1'b1, 1'b0});
            cyc();
            req_valid = 1'b0;
            vectors++;
            if (bus.HTRANS !== HTRANS_IDLE || rsp_valid !== 1'b1 || sb.size() == 0) begin
                miscompares++;
                $display("FAIL misaligned_%0d: htrans=%b rsp_valid=%b queued=%0d, want 00/1/>0", i, bus.HTRANS, rsp_valid, sb.size());
            end else begin
                e = sb.pop_front();
                if (rsp_err !== e.err || rsp_last !== e.last) begin
                    miscompares++;
                    $display("FAIL misaligned_rsp_%0d: err=%b last=%b, want %b/%b", i, rsp_err, rsp_last, e.err, e.last);
                end
            end
            cyc();
            vectors++;
            if ({rsp_valid, bus.HTRANS} !== {1'b0, HTRANS_IDLE}) begin
                miscompares++;
                $display("FAIL misaligned_after_%0d: rsp_valid=%b htrans=%b, want 0/00", i, rsp_valid, bus.HTRANS);
            end
        end
    endtask

    task automatic test_back_to_back();
        drive_req(32'h0010_0100, 1'b0, 32'd0, HSIZE_WORD, 1'b0);
        sb.push_back('{32'hAAAA_0001, 1'b0, 1'b1, 1'b1});
        sb.push_back('{32'hBBBB_0002, 1'b0, 1'b1, 1'b1});
        cyc();
        drive_req(32'h0010_0104, 1'b0, 32'd0, HSIZE_WORD, 1'b0);
        bus.HRDATA = 32'hAAAA_0001;
        vectors++;
        if ({req_ready, bus.HTRANS, bus.HADDR} !== {1'b0, HTRANS_NONSEQ, 32'h0010_0100}) begin
            miscompares++;
            $display("FAIL b2b_t1: ready=%b htrans=%b haddr=%h, want 0/10/00100100", req_ready, bus.HTRANS, bus.HADDR);
        end
        cyc();
        cyc();
        bus.HRDATA = 32'hBBBB_0002;
        vectors++;
        if (rsp_valid !== 1'b1 || req_ready !== 1'b1 || sb.size() == 0) begin
            miscompares++;
            $display("FAIL b2b_t3: rsp_valid=%b ready=%b queued=%0d, want 1/1/>0", rsp_valid, req_ready, sb.size());
        end else begin
            e = sb.pop_front();
            if (rsp_err !== e.err || rsp_last !== e.last || rsp_rdata !== e.rdata) begin
                miscompares++;
                $display("FAIL b2b_rsp_a: err=%b last=%b rdata=%h, want %b/%b/%h", rsp_err, rsp_last, rsp_rdata, e.err, e.last, e.rdata);
            end
        end
        cyc();
        req_valid = 1'b0;
        vectors++;
        if ({bus.HTRANS, bus.HADDR} !== {HTRANS_NONSEQ, 32'h0010_0104}) begin
            miscompares++;
            $display("FAIL b2b_t4: htrans=%b haddr=%h, want 10/00100104", bus.HTRANS, bus.HADDR);
        end
        cyc();
        cyc();
        vectors++;
        if (rsp_valid !== 1'b1 || sb.size() == 0) begin
            miscompares++;
            $display("FAIL b2b_t6: rsp_valid=%b queued=%0d, want 1/>0", rsp_valid, sb.size());
        end else begin
            e = sb.pop_front();
            if (rsp_err !== e.err || rsp_last !== e.last || rsp_rdata !== e.rdata) begin
                miscompares++;
                $display("FAIL b2b_rsp_b: err=%b last=%b rdata=%h, want %b/%b/%h", rsp_err, rsp_last, rsp_rdata, e.err, e.last, e.rdata);
            end
        end
    endtask

    task automatic test_error_resp();
        cyc();
        drive_req(32'h0000_0000, 1'b0, 32'd0, HSIZE_WORD, 1'b0);
        sb.push_back('{32'd0, 1'b1, 1'b1, 1'b0});
        cyc();
        req_valid = 1'b0;
        cyc();
        bus.HRESP = 1'b1;
        bus.HREADY = 1'b0;
        vectors++;
        if (bus.HTRANS !== HTRANS_IDLE) begin
            miscompares++;
            $display("FAIL err_first_cycle: htrans=%b, want 00", bus.HTRANS);
        end
        cyc();
        bus.HREADY = 1'b1;
        vectors++;
        if ({bus.HTRANS, rsp_valid} !== {HTRANS_IDLE, 1'b0}) begin
            miscompares++;
            $display("FAIL err_wait: htrans=%b rsp_valid=%b, want 00/0", bus.HTRANS, rsp_valid);
        end
        cyc();
        bus.HRESP = 1'b0;
        vectors++;
        if (rsp_valid !== 1'b1 || sb.size() == 0) begin
            miscompares++;
            $display("FAIL err_rsp_valid: rsp_valid=%b queued=%0d, want 1/>0", rsp_valid, sb.size());
        end else begin
            e = sb.pop_front();
            if (rsp_err !== e.err || rsp_last !== e.last) begin
                miscompares++;
                $display("FAIL err_rsp: err=%b last=%b, want %b/%b", rsp_err, rsp_last, e.err, e.last);
            end
        end
    endtask

    task automatic test_reset_mid();
        cyc();
        drive_req(32'h0010_0200, 1'b0, 32'd0, HSIZE_WORD, 1'b0);
        cyc();
        req_valid = 1'b0;
        cyc();
        HRESETn = 1'b0;
        bus.HREADY = 1'b0;
        cyc();
        HRESETn = 1'b1;
        bus.HREADY = 1'b1;
        vectors++;
        if ({bus.HTRANS, rsp_valid, req_ready} !== {HTRANS_IDLE, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL rst_mid_t3: htrans=%b rsp_valid=%b ready=%b, want 00/0/0", bus.HTRANS, rsp_valid, req_ready);
        end
        cyc();
        vectors++;
        if ({req_ready, rsp_valid} !== {1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL rst_mid_release: ready=%b rsp_valid=%b, want 1/0", req_ready, rsp_valid);
        end
        repeat (3) begin
            cyc();
            vectors++;
            if (rsp_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_mid_no_rsp: rsp_valid=%b, want 0", rsp_valid);
            end
        end
    endtask

`ifdef AHB_MST_INCR4_EN
    task automatic test_burst();
        logic [1:0] exp_trans;
        drive_req(32'h0010_0010, 1'b0, 32'd0, HSIZE_WORD, 1'b1);
        for (int k = 0; k < 4; k++) begin
            sb.push_back('{32'hB000_0000 + 32'(k), 1'b0, (k == 3), 1'b1});
        end
        for (int c = 1; c <= 6; c++) begin
            cyc();
            req_valid = 1'b0;
            bus.HRDATA = 32'hB000_0000 + 32'(c - 2);
            if (c <= 5) begin
                exp_trans = (c == 1) ? HTRANS_NONSEQ : ((c == 5) ? HTRANS_IDLE : HTRANS_SEQ);
                vectors++;
                if (bus.HTRANS !== exp_trans || (c < 5 && (bus.HADDR !== 32'h0010_0010 + 32'(4 * (c - 1)) ||
                    bus.HBURST !== HBURST_INCR4 || bus.HSIZE !== HSIZE_WORD))) begin
                    miscompares++;
                    $display("FAIL burst_addr_t%0d: htrans=%b haddr=%h hburst=%b, want %b/%h/011", c, bus.HTRANS, bus.HADDR, bus.HBURST, exp_trans, 32'h0010_0010 + 32'(4 * (c - 1)));
                end
            end
            vectors++;
            if (c < 3) begin
                if (rsp_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL burst_early_t%0d: rsp_valid=%b, want 0", c, rsp_valid);
                end
            end else if (rsp_valid !== 1'b1 || sb.size() == 0) begin
                miscompares++;
                $display("FAIL burst_beat_t%0d: rsp_valid=%b queued=%0d, want 1/>0", c, rsp_valid, sb.size());
            end else begin
                e = sb.pop_front();
                if (rsp_err !== e.err || rsp_last !== e.last || rsp_rdata !== e.rdata) begin
                    miscompares++;
                    $display("FAIL burst_rsp_t%0d: err=%b last=%b rdata=%h, want %b/%b/%h", c, rsp_err, rsp_last, rsp_rdata, e.err, e.last, e.rdata);
                end
            end
        end
        drive_req(32'h0010_0014, 1'b0, 32'd0, HSIZE_WORD, 1'b1);
        sb.push_back('{32'd0, 1'b1, 1'b1, 1'b0});
        cyc();
        req_valid = 1'b0;
        vectors++;
        if (bus.HTRANS !== HTRANS_IDLE || rsp_valid !== 1'b1 || sb.size() == 0) begin
            miscompares++;
            $display("FAIL burst_misaligned: htrans=%b rsp_valid=%b, want 00/1", bus.HTRANS, rsp_valid);
        end else begin
            e = sb.pop_front();
            if (rsp_err !== e.err || rsp_last !== e.last) begin
                miscompares++;
                $display("FAIL burst_misaligned_rsp: err=%b last=%b, want 1/1", rsp_err, rsp_last);
            end
        end
        cyc();
    endtask
`else
    task automatic test_burst_ignored();
        drive_req(32'h0010_0010, 1'b0, 32'd0, HSIZE_WORD, 1'b1);
        bus.HRDATA = 32'hC0DE_0010;
        sb.push_back('{32'hC0DE_0010, 1'b0, 1'b1, 1'b1});
        cyc();
        req_valid = 1'b0;
        vectors++;
        if ({bus.HTRANS, bus.HBURST} !== {HTRANS_NONSEQ, HBURST_SINGLE}) begin
            miscompares++;
            $display("FAIL burst_ignored_t1: htrans=%b hburst=%b, want 10/000", bus.HTRANS, bus.HBURST);
        end
        cyc();
        vectors++;
        if (bus.HTRANS !== HTRANS_IDLE) begin
            miscompares++;
            $display("FAIL burst_ignored_t2: htrans=%b, want 00", bus.HTRANS);
        end
        cyc();
        vectors++;
        if (rsp_valid !== 1'b1 || sb.size() == 0) begin
            miscompares++;
            $display("FAIL burst_ignored_t3: rsp_valid=%b queued=%0d, want 1/>0", rsp_valid, sb.size());
        end else begin
            e = sb.pop_front();
            if (rsp_err !== e.err || rsp_last !== e.last || rsp_rdata !== e.rdata) begin
                miscompares++;
                $display("FAIL burst_ignored_rsp: err=%b last=%b rdata=%h, want %b/%b/%h", rsp_err, rsp_last, rsp_rdata, e.err, e.last, e.rdata);
            end
        end
        cyc();
    endtask
`endif

    initial begin
        test_reset();
        test_read();
        test_write_wait();
        test_addr_wait();
        test_misaligned();
        test_back_to_back();
        test_error_resp();
`ifdef AHB_MST_INCR4_EN
        test_burst();
`else
        test_burst_ignored();
`endif
        test_reset_mid();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d responses still expected, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
